// File: rtl/bitr_pkg.sv
// Shared definitions for the digit-reversal reorder buffer: frame lengths, mode
// encoding, bank states and the per-mode digit radices / address weights.
package bitr_pkg;

  localparam int unsigned NMax = 45;
  localparam int unsigned N9   = 9;
  localparam int unsigned N15  = 15;
  localparam int unsigned N45  = 45;

  localparam logic [2:0] SelId0 = 3'd0;
  localparam logic [2:0] SelId1 = 3'd1;
  localparam logic [2:0] SelN15 = 3'd2;
  localparam logic [2:0] SelN45 = 3'd3;
  localparam logic [2:0] SelN9  = 3'd4;

  typedef enum logic [1:0] {
    BankEmpty    = 2'd0,
    BankFilling  = 2'd1,
    BankFull     = 2'd2,
    BankDraining = 2'd3
  } bank_st_e;

  // Radices r* bound each digit; addr = w0*d0 + w1*d1 + w2*d2.
  typedef struct packed {
    logic [5:0] r0;
    logic [2:0] r1;
    logic [2:0] r2;
    logic [5:0] w0;
    logic [5:0] w1;
    logic [5:0] w2;
  } digit_cfg_t;

  function automatic logic sel_valid(input logic [2:0] s);
    return s <= SelN9;
  endfunction

  function automatic logic [5:0] frame_len(input logic [2:0] s);
    case (s)
      SelN15:  return 6'(N15);
      SelN9:   return 6'(N9);
      default: return 6'(N45);
    endcase
  endfunction

  function automatic digit_cfg_t digit_cfg(input logic [2:0] s);
    digit_cfg_t c;
    case (s)
      SelN15:  c = '{r0: 6'd5,  r1: 3'd3, r2: 3'd1, w0: 6'd3,  w1: 6'd1, w2: 6'd0};
      SelN45:  c = '{r0: 6'd3,  r1: 3'd3, r2: 3'd5, w0: 6'd15, w1: 6'd5, w2: 6'd1};
      SelN9:   c = '{r0: 6'd3,  r1: 3'd3, r2: 3'd1, w0: 6'd3,  w1: 6'd1, w2: 6'd0};
      default: c = '{r0: 6'd45, r1: 3'd1, r2: 3'd1, w0: 6'd1,  w1: 6'd0, w2: 6'd0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bitr_addr_gen.sv
// Mixed-radix digit counters producing the digit-reversed write address of the
// current input sample.
module bitr_addr_gen
  import bitr_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advance,
  input  logic       clear,
  input  logic [2:0] sel,
  output logic [5:0] addr
);

  logic [5:0] d0_q, d0_d;
  logic [2:0] d1_q, d1_d;
  logic [2:0] d2_q, d2_d;
  digit_cfg_t cfg;

  always_comb begin
    cfg  = digit_cfg(sel);
    d0_d = d0_q;
    d1_d = d1_q;
    d2_d = d2_q;
    if (clear) begin
      d0_d = '0;
      d1_d = '0;
      d2_d = '0;
    end else if (advance) begin
      if (d0_q == cfg.r0 - 6'd1) begin
        d0_d = '0;
        if (d1_q == cfg.r1 - 3'd1) begin
          d1_d = '0;
          d2_d = (d2_q == cfg.r2 - 3'd1) ? 3'd0 : d2_q + 3'd1;
        end else begin
          d1_d = d1_q + 3'd1;
        end
      end else begin
        d0_d = d0_q + 6'd1;
      end
    end
    addr = cfg.w0 * d0_q + cfg.w1 * 6'(d1_q) + cfg.w2 * 6'(d2_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0_q <= '0;
      d1_q <= '0;
      d2_q <= '0;
    end else begin
      d0_q <= d0_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
    end
  end

endmodule

// File: rtl/bitr_reorder_buf.sv
// Ping-pong reorder buffer: digit-reversed samples are scattered into one bank
// while the other bank is read out sequentially in natural order.
module bitr_reorder_buf
  import bitr_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    sel,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  bank_st_e      bank_st_q [2];
  bank_st_e      bank_st_d [2];
  logic [2:0]    sel_q [2];
  logic [2:0]    sel_d [2];
  logic          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          run_q;
  logic [5:0]    wr_cnt_q, wr_cnt_d, q_q, q_d;
  logic [DW-1:0] mem_q [2][NMax];

  bank_st_e   wr_st, rd_st;
  logic [2:0] frame_sel;
  logic [5:0] wr_addr, wr_n, rd_n;
  logic       accept, last_in, out_fire, gen_clear;

  always_comb begin
    wr_st     = bank_st_q[wr_ptr_q];
    rd_st     = bank_st_q[rd_ptr_q];
    // An empty bank takes its mode from the live sel on the first sample.
    frame_sel = (wr_st == BankEmpty) ? sel : sel_q[wr_ptr_q];
    wr_n      = frame_len(frame_sel);
    rd_n      = frame_len(sel_q[rd_ptr_q]);
    in_ready  = run_q && ((wr_st == BankFilling) || ((wr_st == BankEmpty) && sel_valid(sel)));
    accept    = in_valid && in_ready;
    last_in   = accept && (wr_cnt_q == wr_n - 6'd1);
    out_valid = (rd_st == BankFull) || (rd_st == BankDraining);
    out_last  = out_valid && (q_q == rd_n - 6'd1);
    out_data  = mem_q[rd_ptr_q][q_q];
    out_fire  = out_valid && out_ready;
    gen_clear = (wr_st == BankEmpty) && !accept;
  end

  bitr_addr_gen u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (accept),
    .clear   (gen_clear),
    .sel     (frame_sel),
    .addr    (wr_addr)
  );

  // The write bank is never FULL/DRAINING, so write and read never hit the same bank.
  always_comb begin
    bank_st_d = bank_st_q;
    sel_d     = sel_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    wr_cnt_d  = wr_cnt_q;
    q_d       = q_q;
    if (accept) begin
      if (wr_st == BankEmpty) sel_d[wr_ptr_q] = sel;
      bank_st_d[wr_ptr_q] = last_in ? BankFull : BankFilling;
      wr_cnt_d = last_in ? 6'd0 : wr_cnt_q + 6'd1;
      if (last_in) wr_ptr_d = ~wr_ptr_q;
    end
    if (out_fire) begin
      bank_st_d[rd_ptr_q] = out_last ? BankEmpty : BankDraining;
      q_d = out_last ? 6'd0 : q_q + 6'd1;
      if (out_last) rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st_q <= '{BankEmpty, BankEmpty};
      sel_q     <= '{3'd0, 3'd0};
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      wr_cnt_q  <= '0;
      q_q       <= '0;
      run_q     <= 1'b0;
    end else begin
      bank_st_q <= bank_st_d;
      sel_q     <= sel_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_cnt_q  <= wr_cnt_d;
      q_q       <= q_d;
      run_q     <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q][wr_addr] <= in_data;
  end

endmodule

// File: tb/tb_bitr_reorder_buf.sv
// Directed self-checking bench for bitr_reorder_buf.
module tb_bitr_reorder_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  sel = 3'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_last;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int out_q[$];
  int last_q[$];
  int out_cyc[$];
  int acc_cyc[$];

  int exp15[15] = '{0, 5, 10, 1, 6, 11, 2, 7, 12, 3, 8, 13, 4, 9, 14};
  int exp9[9]   = '{0, 3, 6, 1, 4, 7, 2, 5, 8};
  int exp45h[6] = '{0, 9, 18, 27, 36, 3};

  always #5 clk = ~clk;

  bitr_reorder_buf #(.DW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  // Inputs are stable from negedge to posedge, so this sees each handshake.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (in_valid && in_ready) acc_cyc.push_back(cyc);
      if (out_valid && out_ready) begin
        out_q.push_back(int'(out_data));
        last_q.push_back(int'(out_last));
        out_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Natural-order position q holds arrival position src_p(mode, q).
  function automatic int src_p(input int mode, input int q);
    case (mode)
      2:       return q / 3 + 5 * (q % 3);
      4:       return q / 3 + 3 * (q % 3);
      3:       return q / 15 + 3 * ((q % 15) / 5) + 9 * (q % 5);
      default: return q;
    endcase
  endfunction

  task automatic clear_log();
    out_q.delete();
    last_q.delete();
    out_cyc.delete();
    acc_cyc.delete();
  endtask

  task automatic push(input int d, input logic [2:0] s);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = 16'(d);
    sel      = s;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("push_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_outs(input string tag, input int n);
    int t;
    t = 0;
    while (out_q.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    chk(tag, out_q.size(), n);
    @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input int idx, input int mode, input int n,
                             input int base);
    int bad;
    bad = 0;
    for (int q = 0; q < n; q++) begin
      if (idx + q >= out_q.size()) bad++;
      else if (out_q[idx + q] != base + src_p(mode, q) || last_q[idx + q] != int'(q == n - 1))
        bad++;
    end
    chk(tag, bad, 0);
  endtask

  initial begin
    int lasts;
    int gaps;
    rst_n     = 1'b0;
    sel       = 3'd2;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("in_ready_before_edge", int'(in_ready), 0);
    @(posedge clk);
    #1;
    chk("in_ready_after_edge", int'(in_ready), 1);
    out_ready = 1'b1;

    // N=15 frame
    clear_log();
    for (int p = 0; p < 15; p++) push(p, 3'd2);
    in_valid = 1'b0;
    wait_outs("n15_count", 15);
    for (int q = 0; q < 15; q++) begin
      chk("n15_data", out_q[q], exp15[q]);
      chk("n15_last", last_q[q], int'(q == 14));
    end
    chk("n15_latency", out_cyc[0], acc_cyc[14] + 1);

    // N=9 then N=45
    clear_log();
    for (int p = 0; p < 9; p++) push(p, 3'd4);
    in_valid = 1'b0;
    wait_outs("n9_count", 9);
    for (int q = 0; q < 9; q++) begin
      chk("n9_data", out_q[q], exp9[q]);
      chk("n9_last", last_q[q], int'(q == 8));
    end
    clear_log();
    for (int p = 0; p < 45; p++) push(p, 3'd3);
    in_valid = 1'b0;
    wait_outs("n45_count", 45);
    for (int q = 0; q < 6; q++) chk("n45_head", out_q[q], exp45h[q]);
    chk("n45_tail", out_q[44], 44);
    lasts = 0;
    foreach (last_q[k]) lasts += last_q[k];
    chk("n45_last_count", lasts, 1);
    chk("n45_last_pos", last_q[44], 1);

    // Three back-to-back N=45 frames at full rate
    clear_log();
    for (int f = 0; f < 3; f++)
      for (int p = 0; p < 45; p++) push(f * 64 + p, 3'd3);
    in_valid = 1'b0;
    wait_outs("b2b_count", 135);
    gaps = 0;
    for (int k = 1; k < acc_cyc.size(); k++) if (acc_cyc[k] != acc_cyc[k-1] + 1) gaps++;
    chk("b2b_in_gaps", gaps, 0);
    gaps = 0;
    for (int k = 1; k < out_cyc.size(); k++) if (out_cyc[k] != out_cyc[k-1] + 1) gaps++;
    chk("b2b_out_gaps", gaps, 0);
    chk("b2b_latency", out_cyc[0], acc_cyc[44] + 1);
    for (int f = 0; f < 3; f++) check_frame("b2b_frame", f * 45, 3, 45, f * 64);

    // Backpressure until both banks are full
    out_ready = 1'b0;
    clear_log();
    for (int p = 0; p < 45; p++) push(200 + p, 3'd3);
    for (int p = 0; p < 45; p++) push(300 + p, 3'd3);
    in_data = 16'd999;
    repeat (3) @(negedge clk);
    chk("bp_in_ready", int'(in_ready), 0);
    chk("bp_out_valid", int'(out_valid), 1);
    chk("bp_out_data", int'(out_data), 200);
    chk("bp_out_last", int'(out_last), 0);
    repeat (5) @(negedge clk);
    chk("bp_hold_valid", int'(out_valid), 1);
    chk("bp_hold_data", int'(out_data), 200);
    chk("bp_accepts", acc_cyc.size(), 90);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_outs("bp_count", 90);
    check_frame("bp_frame_a", 0, 3, 45, 200);
    check_frame("bp_frame_b", 45, 3, 45, 300);

    // sel changes mid-frame
    clear_log();
    for (int p = 0; p < 15; p++) push(p, (p < 7) ? 3'd2 : 3'd4);
    for (int p = 0; p < 9; p++) push(50 + p, 3'd4);
    in_valid = 1'b0;
    wait_outs("selchg_count", 24);
    check_frame("selchg_n15", 0, 2, 15, 0);
    check_frame("selchg_n9", 15, 4, 9, 50);

    // Reset with one frame stored and another half-written
    out_ready = 1'b0;
    clear_log();
    for (int p = 0; p < 45; p++) push(700 + p, 3'd3);
    for (int p = 0; p < 20; p++) push(800 + p, 3'd3);
    in_data = 16'd820;
    @(negedge clk);
    chk("prerst_out_valid", int'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("midrst_in_ready_hold", int'(in_ready), 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_out_valid", int'(out_valid), 0);
    out_ready = 1'b1;
    clear_log();
    for (int p = 0; p < 45; p++) push(500 + p, 3'd3);
    in_valid = 1'b0;
    wait_outs("postrst_count", 45);
    check_frame("postrst_frame", 0, 3, 45, 500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
